// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  localparam int SA_WIDTH_DEFAULT = 8;

  // 2'd3 is unused; the FSM steers it back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the serial adder reuses one instance for
// every bit position.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {Cout,Sum} = A + B + Cin, one bit per clock through a
// single full_adder cell. Operands load on an accepted Start in IDLE, WIDTH
// shift cycles follow, then a DONE cycle publishes the result to registered
// outputs. Define SERIAL_ADDER_OVF_EN to add the signed Overflow output.
//
// state   | meaning
// S_IDLE  | waiting for Start; Sum/Cout hold the last result
// S_SHIFT | one bit per cycle through the full adder; Busy=1
// S_DONE  | result copied to Sum/Cout, Done pulse follows
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_cout;
  logic             last_shift;

  full_adder u_fa (
    .A    (sha_q[0]),
    .B    (shb_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // Counter reaching WIDTH-1 means this edge performs the final shift.
  assign last_shift = (cnt_q == CW'(WIDTH - 1));

  // Next-state, datapath and output decisions; everything holds by default.
  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          sha_d   = A;
          shb_d   = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sha_d   = {1'b0, sha_q[WIDTH-1:1]};
        shb_d   = {1'b0, shb_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_shift) state_d = S_DONE;
      end
      S_DONE: begin
        sum_d   = res_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q == S_SHIFT);
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic msbc_q, msbc_d;
  logic ovf_q, ovf_d;

  // Carry into the MSB is the carry register as the final shift consumes it.
  always_comb begin
    msbc_d = msbc_q;
    ovf_d  = ovf_q;
    if (state_q == S_SHIFT && last_shift) msbc_d = carry_q;
    if (state_q == S_DONE)                ovf_d  = msbc_q ^ carry_q;
  end

  // Overflow registers follow the same reset and hold rules as Cout.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      msbc_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      msbc_q <= msbc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 instance for directed and
// random checks, WIDTH=4 instance for an exhaustive sweep. Expected results
// come from plain integer arithmetic on the operands.
module tb_serial_adder;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .Start(start8), .A(a8), .B(b8), .Cin(cin8),
    .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .Overflow(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Start(start4), .A(a4), .B(b4), .Cin(cin4),
    .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .Overflow(ovf4)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  // Signed overflow: true sum of the two's-complement operands out of range.
  function automatic logic ref_ovf(int a, int b, int c, int w);
    int sa, sb, r;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sa + sb + c;
    return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  // Pulse Start on the 8-bit DUT, scramble inputs, wait for Done.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat, output logic [19:0] bh);
    @(negedge Clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge Clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = -1;
    bh  = '0;
    for (int i = 1; i < 20; i++) begin
      bh[i] = busy8;
      if (done8 === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge Clk);
    end
    s = sum8; co = cout8; ov = ovf8;
  endtask

  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output logic [3:0] s, output logic co, output logic ov,
                        output int lat);
    @(negedge Clk);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    @(negedge Clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat = -1;
    for (int i = 1; i < 20; i++) begin
      if (done4 === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge Clk);
    end
    s = sum4; co = cout4; ov = ovf4;
  endtask

  task automatic test_reset();
    logic seen;
    Rst = 1'b1;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
    repeat (3) @(negedge Clk);
    total++;
    if ({busy8, done8, cout8, sum8, ovf8} !== 12'h000) begin
      bad++;
      $display("FAIL reset8: busy/done/cout/sum/ovf=%b %b %b %h %b want 0", busy8, done8, cout8, sum8, ovf8);
    end
    total++;
    if ({busy4, done4, cout4, sum4, ovf4} !== 8'h00) begin
      bad++;
      $display("FAIL reset4: busy/done/cout/sum/ovf=%b %b %b %h %b want 0", busy4, done4, cout4, sum4, ovf4);
    end
    // Start alongside reset must be dropped.
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge Clk);
    Rst = 1'b0; start8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (busy8 !== 1'b0 || done8 !== 1'b0) seen = 1'b1;
      @(negedge Clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_start_same_edge: activity=%b want 0", seen);
    end
  endtask

  task automatic test_latency();
    logic [7:0] s; logic co, ov; int lat; logic [19:0] bh;
    do_op8(8'h5A, 8'h3C, 1'b0, s, co, ov, lat, bh);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL latency: done at cycle %0d want 10", lat);
    end
    total++;
    if (bh !== 20'h001FE) begin
      bad++;
      $display("FAIL busy_window: busy history %h want 001fe", bh);
    end
    total++;
    if ({co, s} !== 9'h096) begin
      bad++;
      $display("FAIL sum_5a_3c: got %h want 096", {co, s});
    end
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (ov !== 1'b1) begin
      bad++;
      $display("FAIL ovf_5a_3c: got %b want 1", ov);
    end
`endif
    @(negedge Clk);
    total++;
    if (done8 !== 1'b0 || sum8 !== 8'h96) begin
      bad++;
      $display("FAIL done_pulse_hold: done=%b sum=%h want 0 96", done8, sum8);
    end
  endtask

  task automatic test_directed();
    logic [7:0] s; logic co, ov; int lat; logic [19:0] bh;
    do_op8(8'hFF, 8'h01, 1'b0, s, co, ov, lat, bh);
    total++;
    if ({co, s} !== 9'h100 || lat !== 10) begin
      bad++;
      $display("FAIL ff_plus_01: got %h lat %0d want 100 lat 10", {co, s}, lat);
    end
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (ov !== 1'b0) begin
      bad++;
      $display("FAIL ovf_ff_01: got %b want 0", ov);
    end
`endif
    do_op8(8'hFF, 8'hFF, 1'b1, s, co, ov, lat, bh);
    total++;
    if ({co, s} !== 9'h1FF || lat !== 10) begin
      bad++;
      $display("FAIL ff_ff_cin: got %h lat %0d want 1ff lat 10", {co, s}, lat);
    end
  endtask

  task automatic test_start_held();
    int dones, busy_cycles;
    logic [7:0] s_at_done; logic c_at_done;
    @(negedge Clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(negedge Clk);
    a8 = 8'hAA; b8 = 8'hAA;
    dones = 0; busy_cycles = 0; s_at_done = '0; c_at_done = 1'b0;
    for (int i = 1; i < 25; i++) begin
      if (busy8 === 1'b1) busy_cycles++;
      else start8 = 1'b0;
      if (done8 === 1'b1) begin
        dones++;
        s_at_done = sum8; c_at_done = cout8;
      end
      @(negedge Clk);
    end
    start8 = 1'b0;
    total++;
    if (dones !== 1 || busy_cycles !== 8) begin
      bad++;
      $display("FAIL start_held_count: dones=%0d busy=%0d want 1 8", dones, busy_cycles);
    end
    total++;
    if ({c_at_done, s_at_done} !== 9'h046) begin
      bad++;
      $display("FAIL start_held_sum: got %h want 046", {c_at_done, s_at_done});
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge Clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1;
    @(negedge Clk);
    start8 = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    total++;
    if ({busy8, done8, cout8, sum8, ovf8} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid: busy/done/cout/sum/ovf=%b %b %b %h %b want 0", busy8, done8, cout8, sum8, ovf8);
    end
    Rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
      @(negedge Clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_no_done: activity=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s; logic co, ov; int lat; logic [19:0] bh;
    int held_bad, lat2;
    do_op8(8'hFF, 8'hFF, 1'b1, s, co, ov, lat, bh);
    @(negedge Clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    @(negedge Clk);
    start8 = 1'b0;
    held_bad = 0; lat2 = -1;
    for (int i = 1; i < 20; i++) begin
      if (done8 === 1'b1) begin
        lat2 = i;
        break;
      end
      if (sum8 !== 8'hFF || cout8 !== 1'b1) held_bad++;
      @(negedge Clk);
    end
    total++;
    if (held_bad !== 0 || lat2 !== 10) begin
      bad++;
      $display("FAIL b2b_hold: hold errors=%0d lat=%0d want 0 10", held_bad, lat2);
    end
    total++;
    if ({cout8, sum8} !== 9'h100) begin
      bad++;
      $display("FAIL b2b_sum: got %h want 100", {cout8, sum8});
    end
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (ovf8 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ovf: got %b want 1", ovf8);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] a, b, s; logic c, co, ov; int lat, r; logic [19:0] bh;
    for (int n = 0; n < 200; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      do_op8(a, b, c, s, co, ov, lat, bh);
      r = int'(a) + int'(b) + int'(c);
      total++;
      if ({co, s} !== 9'(r) || lat !== 10) begin
        bad++;
        $display("FAIL rand8 %h+%h+%b: got %h lat %0d want %h lat 10", a, b, c, {co, s}, lat, 9'(r));
      end
`ifdef SERIAL_ADDER_OVF_EN
      total++;
      if (ov !== ref_ovf(int'(a), int'(b), int'(c), 8)) begin
        bad++;
        $display("FAIL rand8_ovf %h+%h+%b: got %b", a, b, c, ov);
      end
`endif
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [3:0] s; logic co, ov; int lat, r;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          do_op4(4'(a), 4'(b), 1'(c), s, co, ov, lat);
          r = a + b + c;
          total++;
          if ({co, s} !== 5'(r) || lat !== 6) begin
            bad++;
            $display("FAIL w4 %0d+%0d+%0d: got %h lat %0d want %h lat 6", a, b, c, {co, s}, lat, 5'(r));
          end
`ifdef SERIAL_ADDER_OVF_EN
          total++;
          if (ov !== ref_ovf(a, b, c, 4)) begin
            bad++;
            $display("FAIL w4_ovf %0d+%0d+%0d: got %b", a, b, c, ov);
          end
`endif
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_exhaustive_w4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
